// File: rtl/updn_cnt_sequencer.sv
// ---------------------------------------------------------------------------
// updn_cnt_sequencer
//
// Command-driven controller for a WIDTH-bit up/down counter. One command is
// taken at a time over cmd_valid/cmd_ready. The block drives the counter's
// load, direction and enable pins and watches cnt_q to know when to stop.
//
// Commands (cmd_op):
//   00 NOP    - consumed, done pulses the next cycle
//   01 LOAD   - one-cycle parallel load of cmd_a
//   10 RUN_TO - count toward cmd_a until cnt_q == cmd_a
//   11 SWEEP  - load cmd_a, then bounce a->b->a cmd_reps times
//               (rejected with err when cmd_a >= cmd_b)
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE; cmd_a/cmd_b/cmd_reps are captured on that edge.
// The source may hold or drop cmd_valid freely while cmd_ready is low.
//
// Ports:
//   clk, rst_      clock (rising edge), asynchronous active-low reset
//   cmd_*          command interface (see above)
//   abort          drops the current command at the next edge (ignored in IDLE)
//   cnt_q          counter value feedback
//   cnt_data       counter parallel-load data
//   cnt_ld_n       counter load, active low
//   cnt_updn       counter direction, 1 = up
//   cnt_enb        counter count enable
//   busy           high in any non-IDLE state
//   done / err     registered one-cycle completion / rejection pulses
//   state_dbg      current FSM state, for debug and checker binding
// ---------------------------------------------------------------------------
module updn_cnt_sequencer #(
  parameter int WIDTH  = 3,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_q,
  output logic [WIDTH-1:0]  cnt_data,
  output logic              cnt_ld_n,
  output logic              cnt_updn,
  output logic              cnt_enb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_SLOAD = 3'd3;
  localparam logic [2:0] S_SUP   = 3'd4;
  localparam logic [2:0] S_SDN   = 3'd5;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_SWEEP = 2'b11;

  localparam logic [REPS_W-1:0] REPS_ONE = {{(REPS_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [REPS_W-1:0] reps_q, reps_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              ld_raw;
  logic              enb_raw;
  logic              abort_act;

  assign abort_act = abort && (state_q != S_IDLE);

  // Next-state and operand logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    reps_d  = reps_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d    = cmd_a;
          b_d    = cmd_b;
          reps_d = cmd_reps;
          case (cmd_op)
            OP_NOP:  done_d  = 1'b1;
            OP_LOAD: state_d = S_LOAD;
            OP_RUN:  state_d = S_RUN;
            OP_SWEEP: begin
              // An empty or inverted sweep range is rejected before any
              // counter activity.
              if (cmd_a >= cmd_b) err_d   = 1'b1;
              else                state_d = S_SLOAD;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_LOAD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      S_RUN: begin
        if (cnt_q == a_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_SLOAD: begin
        if (reps_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SUP;
        end
      end

      S_SUP: begin
        // The cycle spent at the high bound with enable low is the turnaround.
        if (cnt_q == b_q) state_d = S_SDN;
      end

      S_SDN: begin
        if (cnt_q == a_q) begin
          reps_d = reps_q - REPS_ONE;
          if (reps_q == REPS_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SUP;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over any completion decided in the same cycle.
    if (abort_act) begin
      state_d = S_IDLE;
      reps_d  = reps_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      reps_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      reps_q  <= reps_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Counter drive: combinational from state, operands and feedback. Enables
  // drop as soon as cnt_q sits on the active bound, so the counter never
  // steps past a target.
  always_comb begin
    ld_raw   = 1'b0;
    enb_raw  = 1'b0;
    cnt_updn = 1'b0;
    case (state_q)
      S_LOAD, S_SLOAD: ld_raw = 1'b1;
      S_RUN: begin
        cnt_updn = (a_q > cnt_q);
        enb_raw  = (cnt_q != a_q);
      end
      S_SUP: begin
        cnt_updn = 1'b1;
        enb_raw  = (cnt_q != b_q);
      end
      S_SDN: begin
        cnt_updn = 1'b0;
        enb_raw  = (cnt_q != a_q);
      end
      default: begin
        ld_raw   = 1'b0;
        enb_raw  = 1'b0;
        cnt_updn = 1'b0;
      end
    endcase
  end

  assign cnt_ld_n  = !(ld_raw && !abort_act);
  assign cnt_enb   = enb_raw && !abort_act;
  assign cnt_data  = ld_raw ? a_q : '0;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
